wb_core_bus_arbiter: RTL

//  Two-master to one-slave Wishbone classic arbiter for custom_riscv_core.

---
 rtl/wb_core_bus_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/wb_core_bus_arbiter.sv
// wb_core_bus_arbiter
// Two-master (iwb fetch, dwb load/store) to one-slave Wishbone classic arbiter.
// A grant is held for a whole bus cycle. It is released on slave ack/err, on
// a master abort (owner drops cyc), or on the optional watchdog.
// A registered IDLE cycle always separates two transfers.
// Optional feature: define WB_ARB_TIMEOUT_EN to build the grant watchdog,
// which errors the owner after TIMEOUT_CYCLES cycles without a slave response.
module wb_core_bus_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  // instruction master
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  // data master
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  // shared slave
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  // grant status
  output logic [1:0]  gnt_o
);

  // State encoding doubles as the gnt_o code: 00 none, 01 iwb, 10 dwb.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_d_q, last_d_d;   // 1: dwb won the last completed transfer
  logic   req_i, req_d;
  logic   slv_done;             // slave ended the cycle with ack or err
  logic   tmo_hit;              // watchdog fires in this cycle

  assign req_i    = iwb_cyc_i & iwb_stb_i;
  assign req_d    = dwb_cyc_i & dwb_stb_i;
  assign slv_done = s_ack_i | s_err_i;

  // Read data is broadcast; each master qualifies it with its own ack.
  assign iwb_dat_o = s_dat_i;
  assign dwb_dat_o = s_dat_i;
  assign gnt_o     = state_q;

  // A watchdog below 2 cycles could never let a slave answer.
  if (TIMEOUT_CYCLES < 2) begin : g_tmo_range
    $error("wb_core_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog count: zero while idle so each grant starts fresh, then counts
  // every granted cycle the slave leaves unanswered.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (!slv_done && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state arbitration and the combinational owner mux.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    last_d_d  = last_d_q;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stray slave ack/err is never forwarded here.
        if (req_i && req_d) begin
          state_d = ((ROUND_ROBIN != 0) && last_d_q) ? GNT_I : GNT_D;
        end else if (req_d) begin
          state_d = GNT_D;
        end else if (req_i) begin
          state_d = GNT_I;
        end
      end

      GNT_I: begin
        // Fetches are always full-word reads.
        s_adr_o = iwb_adr_i;
        s_sel_o = 4'hF;
        s_cyc_o = iwb_cyc_i & ~tmo_hit;
        s_stb_o = iwb_stb_i & ~tmo_hit;
        if (tmo_hit) begin
          iwb_err_o = 1'b1;
        end else begin
          iwb_ack_o = s_ack_i;
          iwb_err_o = s_err_i;
        end
        if (tmo_hit || slv_done) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end else if (!iwb_cyc_i) begin
          state_d = IDLE;   // abort: the winner history stays as it was
        end
      end

      GNT_D: begin
        s_adr_o = dwb_adr_i;
        s_dat_o = dwb_dat_i;
        s_we_o  = dwb_we_i;
        s_sel_o = dwb_sel_i;
        s_cyc_o = dwb_cyc_i & ~tmo_hit;
        s_stb_o = dwb_stb_i & ~tmo_hit;
        if (tmo_hit) begin
          dwb_err_o = 1'b1;
        end else begin
          dwb_ack_o = s_ack_i;
          dwb_err_o = s_err_i;
        end
        if (tmo_hit || slv_done) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end else if (!dwb_cyc_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and last-winner registers; reset leaves iwb as last winner so dwb
  // takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

endmodule
